// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor; valid/ready semantics: start is
// honoured only when busy=0 (IDLE or DONE cycle), done pulses once per accepted start.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] Diff;
   logic         Bout;
   state_t       dbg_state;

   modport master (
      output start, A, B,
      input  busy, done, Diff, Bout, dbg_state
   );

   modport slave (
      input  start, A, B,
      output busy, done, Diff, Bout, dbg_state
   );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B mod 2^N, LSB first, one bit per clock.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  r_q, r_d;
   logic [N-1:0]  diff_q, diff_d;
   logic [N-1:0]  r_shift;
   logic          bin_q, bin_d;
   logic          bout_q, bout_d;
   logic          d_bit, bout_bit;
   logic          accept;

   full_subtractor u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (bin_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   // A new request is taken in IDLE and also in the DONE cycle (back-to-back).
   assign accept = bus.start && (state_q != SHIFT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      diff_d  = diff_q;
      bin_d   = bin_q;
      bout_d  = bout_q;
      r_shift = r_q >> 1;
      r_shift[N-1] = d_bit;

      case (state_q)
         IDLE: begin
            if (accept) state_d = SHIFT;
         end
         SHIFT: begin
            r_d   = r_shift;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            bin_d = bout_bit;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               diff_d  = r_shift;
               bout_d  = bout_bit;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = accept ? SHIFT : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         a_d   = bus.A;
         b_d   = bus.B;
         r_d   = '0;
         bin_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         diff_q  <= '0;
         bin_q   <= 1'b0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         diff_q  <= diff_d;
         bin_q   <= bin_d;
         bout_q  <= bout_d;
      end
   end

   assign bus.busy      = (state_q == SHIFT);
   assign bus.done      = (state_q == DONE);
   assign bus.Diff      = diff_q;
   assign bus.Bout      = bout_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and round-trip bench for serial_subtractor at N=8, N=1 and N=16.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   serial_subtractor_if #(.N(8))  bus8 ();
   serial_subtractor_if #(.N(1))  bus1 ();
   serial_subtractor_if #(.N(16)) bus16 ();

   serial_subtractor #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   serial_subtractor #(.N(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
   serial_subtractor #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b);
      case (w)
         1: begin bus1.start = st; bus1.A = a[0]; bus1.B = b[0]; end
         16: begin bus16.start = st; bus16.A = a; bus16.B = b; end
         default: begin bus8.start = st; bus8.A = a[7:0]; bus8.B = b[7:0]; end
      endcase
   endtask

   task automatic sample(input int w, output logic bz, output logic dn,
                         output logic [15:0] df, output logic bo);
      case (w)
         1: begin bz = bus1.busy; dn = bus1.done; df = {15'd0, bus1.Diff}; bo = bus1.Bout; end
         16: begin bz = bus16.busy; dn = bus16.done; df = bus16.Diff; bo = bus16.Bout; end
         default: begin bz = bus8.busy; dn = bus8.done; df = {8'd0, bus8.Diff}; bo = bus8.Bout; end
      endcase
   endtask

   // Issue one request and wait (bounded) for its done pulse; lat counts edges after acceptance.
   task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_n, output logic [15:0] diff,
                        output logic bout, output bit seen);
      logic bz, dn, bo;
      logic [15:0] df;
      @(negedge clk);
      drive(w, 1'b1, a, b);
      @(negedge clk);
      drive(w, 1'b0, ~a, ~b);
      lat = 0; busy_n = 0; seen = 0; diff = '0; bout = 1'b0;
      while (!seen && lat < 40) begin
         sample(w, bz, dn, df, bo);
         if (dn) begin
            seen = 1; diff = df; bout = bo;
         end else begin
            if (bz) busy_n++;
            @(negedge clk);
            lat++;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(8, 1'b0, 16'h0, 16'h0);
      drive(1, 1'b0, 16'h0, 16'h0);
      drive(16, 1'b0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus8.busy); end
      checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus8.done); end
      checks++; if (bus8.Diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", bus8.Diff); end
      checks++; if (bus8.Bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bus8.Bout); end
      checks++; if (bus8.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", bus8.dbg_state); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int lat, busy_n; logic [15:0] df; logic bo; bit seen;
      do_op(8, 16'h0F, 16'h01, lat, busy_n, df, bo, seen);
      checks++; if (!seen) begin errors++; $display("FAIL basic_done got none want pulse"); end
      checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
      checks++; if (busy_n != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", busy_n); end
      checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", bus8.busy); end
      checks++; if (df[7:0] !== 8'h0E) begin errors++; $display("FAIL basic_diff got %h want 0e", df[7:0]); end
      checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bout got %b want 0", bo); end
   endtask

   task automatic test_wrap;
      int lat, busy_n; logic [15:0] df; logic bo; bit seen;
      do_op(8, 16'h00, 16'h01, lat, busy_n, df, bo, seen);
      checks++; if (!seen || df[7:0] !== 8'hFF) begin errors++; $display("FAIL wrap_00_01_diff got %h want ff", df[7:0]); end
      checks++; if (bo !== 1'b1) begin errors++; $display("FAIL wrap_00_01_bout got %b want 1", bo); end
      do_op(8, 16'hAA, 16'h55, lat, busy_n, df, bo, seen);
      checks++; if (!seen || df[7:0] !== 8'h55) begin errors++; $display("FAIL aa_55_diff got %h want 55", df[7:0]); end
      checks++; if (bo !== 1'b0) begin errors++; $display("FAIL aa_55_bout got %b want 0", bo); end
      do_op(8, 16'h55, 16'hAA, lat, busy_n, df, bo, seen);
      checks++; if (!seen || df[7:0] !== 8'hAB) begin errors++; $display("FAIL 55_aa_diff got %h want ab", df[7:0]); end
      checks++; if (bo !== 1'b1) begin errors++; $display("FAIL 55_aa_bout got %b want 1", bo); end
   endtask

   task automatic test_ignore_start;
      int dones = 0;
      logic [7:0] df = 8'hXX;
      logic bo = 1'bx;
      @(negedge clk);
      drive(8, 1'b1, 16'h81, 16'h81);
      @(negedge clk);
      drive(8, 1'b0, 16'h00, 16'h00);
      repeat (3) @(negedge clk);
      drive(8, 1'b1, 16'hFF, 16'hFF);
      @(negedge clk);
      drive(8, 1'b0, 16'h00, 16'h00);
      for (int i = 0; i < 24; i++) begin
         if (bus8.done) begin dones++; df = bus8.Diff; bo = bus8.Bout; end
         @(negedge clk);
      end
      checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
      checks++; if (df !== 8'h00) begin errors++; $display("FAIL equal_diff got %h want 00", df); end
      checks++; if (bo !== 1'b0) begin errors++; $display("FAIL equal_bout got %b want 0", bo); end
   endtask

   task automatic test_back_to_back;
      int lat, busy_n, gap; logic [15:0] df; logic bo; bit seen;
      do_op(8, 16'h0F, 16'h01, lat, busy_n, df, bo, seen);
      checks++; if (!seen || df[7:0] !== 8'h0E) begin errors++; $display("FAIL b2b_first_diff got %h want 0e", df[7:0]); end
      drive(8, 1'b1, 16'hF0, 16'h0F);
      @(negedge clk);
      drive(8, 1'b0, 16'h00, 16'h00);
      gap = 1;
      while (!bus8.done && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      checks++; if (gap != 9) begin errors++; $display("FAIL b2b_gap got %0d want 9", gap); end
      checks++; if (bus8.Diff !== 8'hE1) begin errors++; $display("FAIL b2b_diff got %h want e1", bus8.Diff); end
      checks++; if (bus8.Bout !== 1'b0) begin errors++; $display("FAIL b2b_bout got %b want 0", bus8.Bout); end
   endtask

   task automatic test_reset_mid_shift;
      int dones = 0;
      int lat, busy_n; logic [15:0] df; logic bo; bit seen;
      @(negedge clk);
      drive(8, 1'b1, 16'h3C, 16'h11);
      @(negedge clk);
      drive(8, 1'b0, 16'h00, 16'h00);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus8.busy); end
      checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus8.done); end
      checks++; if (bus8.Diff !== 8'h00) begin errors++; $display("FAIL midrst_diff got %h want 00", bus8.Diff); end
      checks++; if (bus8.Bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %b want 0", bus8.Bout); end
      for (int i = 0; i < 15; i++) begin
         if (bus8.done) dones++;
         @(negedge clk);
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      do_op(8, 16'h3C, 16'h11, lat, busy_n, df, bo, seen);
      checks++; if (!seen || lat != 8) begin errors++; $display("FAIL midrst_fresh_latency got %0d want 8", lat); end
      checks++; if (df[7:0] !== 8'h2B || bo !== 1'b0) begin errors++; $display("FAIL midrst_fresh_result got %h/%b want 2b/0", df[7:0], bo); end
   endtask

   // Adder model: Sum = A+B mod 2^w, Cout = carry; subtracting B from Sum must give A, Bout=Cout.
   task automatic test_round_trip(input int w);
      int lat, busy_n; logic [15:0] df; logic bo; bit seen;
      logic [15:0] mask, a, b, sum;
      logic [16:0] s, exp;
      mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom_range(0, 65535)) & mask;
         b = 16'($urandom_range(0, 65535)) & mask;
         s = {1'b0, a} + {1'b0, b};
         sum = s[15:0] & mask;
         exp_q.push_back({s[w], a});
         do_op(w, sum, b, lat, busy_n, df, bo, seen);
         exp = exp_q.pop_front();
         checks++; if (!seen || lat != w) begin errors++; $display("FAIL rt%0d_latency got %0d want %0d", w, lat, w); end
         checks++; if (df !== exp[15:0]) begin errors++; $display("FAIL rt%0d_diff got %h want %h", w, df, exp[15:0]); end
         checks++; if (bo !== exp[16]) begin errors++; $display("FAIL rt%0d_bout got %b want %b", w, bo, exp[16]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_shift();
      test_round_trip(8);
      test_round_trip(1);
      test_round_trip(16);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
